// File: rtl/axi4stream_output_serializer_pkg.sv
// Shared stream constants: word/beat widths and input-buffer sizing agreed by both stages,
// plus the serializer FSM state type.
package axi4stream_output_serializer_pkg;

    localparam int STREAM_DATA_W = 8;
    localparam int STREAM_BUF_W  = 40;
    localparam int STREAM_BEATS  = STREAM_BUF_W / STREAM_DATA_W;

    // Input-buffer stage sizing
    localparam int IBUF_DEPTH    = 4;
    localparam int IBUF_PTR_W    = $clog2(IBUF_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/axi4stream_output_serializer.sv
// Wide-word to AXI4-Stream serializer: accepts BUF_W-bit words and emits them LSB-first
// as BUF_W/DATA_W beats, with tlast on the final beat and no bubble between back-to-back words.
module axi4stream_output_serializer
    import axi4stream_output_serializer_pkg::*;
#(
    parameter int DATA_W = STREAM_DATA_W,
    parameter int BUF_W  = STREAM_BUF_W
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [BUF_W-1:0]  buffer,
    input  logic              buf_valid,
    output logic              buf_ready,
    output logic [DATA_W-1:0] tdata,
    output logic              tvalid,
    input  logic              tready,
    output logic              tlast
);

    localparam int BEATS = BUF_W / DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    ser_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [BUF_W-1:0] shreg;
    logic             on_last;

    assign on_last   = (state == SEND) && (cnt == LAST_CNT);
    assign tvalid    = (state == SEND);
    assign tlast     = on_last;
    assign tdata     = shreg[DATA_W-1:0];
    // Ready is combinational from tready so the next word loads on the final beat edge.
    assign buf_ready = !areset && ((state == IDLE) || (on_last && tready));

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (buf_valid) begin
                        shreg <= buffer;
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (tready) begin
                        if (cnt == LAST_CNT) begin
                            cnt <= '0;
                            if (buf_valid) begin
                                shreg <= buffer;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            shreg <= shreg >> DATA_W;
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4stream_output_serializer.sv
// Self-checking bench: directed scenarios plus random traffic, compared each cycle
// against a queue-of-beats reference model of the serializer.
module tb_axi4stream_output_serializer;

    localparam int DATA_W = 8;
    localparam int BUF_W  = 40;
    localparam int BEATS  = BUF_W / DATA_W;

    logic              aclk = 1'b0;
    logic              areset;
    logic [BUF_W-1:0]  buffer;
    logic              buf_valid;
    logic              buf_ready;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    always #5 aclk = ~aclk;

    axi4stream_output_serializer #(.DATA_W(DATA_W), .BUF_W(BUF_W)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .buffer    (buffer),
        .buf_valid (buf_valid),
        .buf_ready (buf_ready),
        .tdata     (tdata),
        .tvalid    (tvalid),
        .tready    (tready),
        .tlast     (tlast)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    beat_t             model_q[$];
    logic [DATA_W-1:0] got[$];
    logic [DATA_W-1:0] exp_q[$];
    int                tests = 0;
    int                fails = 0;
    logic              after_rst = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check ready, advance the model at the edge,
    // then check the registered outputs at the following negedge.
    task automatic step(input logic bv, input logic [BUF_W-1:0] bw, input logic tr, input logic rst);
        logic exp_ready;
        buf_valid = bv;
        buffer    = bw;
        tready    = tr;
        areset    = rst;
        #1;
        exp_ready = !rst && (model_q.size() == 0 || (model_q.size() == 1 && tr));
        chk("buf_ready", 64'(buf_ready), 64'(exp_ready));
        if (tvalid === 1'b1 && tr && !rst) got.push_back(tdata);
        @(posedge aclk);
        if (rst) begin
            model_q.delete();
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (model_q.size() > 0 && tr) void'(model_q.pop_front());
            if (bv && exp_ready) begin
                for (int k = 0; k < BEATS; k++) begin
                    beat_t b;
                    b.d = bw[k*DATA_W +: DATA_W];
                    b.l = (k == BEATS - 1);
                    model_q.push_back(b);
                end
            end
        end
        @(negedge aclk);
        chk("tvalid", 64'(tvalid), 64'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            chk("tdata", 64'(tdata), 64'(model_q[0].d));
            chk("tlast", 64'(tlast), 64'(model_q[0].l));
        end else begin
            chk("tlast_idle", 64'(tlast), 64'd0);
            if (after_rst) chk("tdata_reset", 64'(tdata), 64'd0);
        end
    endtask

    task automatic cmp_got(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(tag, 64'(got[i]), 64'(exp_q[i]));
        got.delete();
    endtask

    initial begin
        logic [BUF_W-1:0] w1;
        logic [BUF_W-1:0] w2;
        areset = 1'b1; buf_valid = 1'b0; buffer = '0; tready = 1'b0;
        @(negedge aclk);

        // Reset, with buf_valid asserted to show nothing is accepted during reset
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 40'hDEAD_BEEF_01, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        got.delete();

        // Single word, free-flowing
        step(1'b1, 40'h33_22_11_BB_AA, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, BUF_W'({$urandom(), $urandom()}), 1'b1, 1'b0);
        exp_q = '{8'hAA, 8'hBB, 8'h11, 8'h22, 8'h33};
        cmp_got("single");

        // Backpressure during beat BB
        step(1'b1, 40'h33_22_11_BB_AA, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        exp_q = '{8'hAA, 8'hBB, 8'h11, 8'h22, 8'h33};
        cmp_got("backpressure");

        // Back-to-back words with buf_valid held
        w1 = 40'h05_04_03_02_01;
        w2 = 40'h0A_09_08_07_06;
        step(1'b1, w1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, w2, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        cmp_got("back2back");

        // Reset mid-word, then a fresh word
        step(1'b1, 40'h33_22_11_BB_AA, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 40'h77_66_55_44_33, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 40'h44_33_22_11_00, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
        exp_q = '{8'hAA, 8'hBB, 8'h11, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        cmp_got("reset_mid");

        // Late source: bubble, then a word two cycles later
        step(1'b1, w1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, w2, 1'b1, 1'b0);
        step(1'b0, w2, 1'b1, 1'b0);
        step(1'b1, w2, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        cmp_got("late_src");

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), BUF_W'({$urandom(), $urandom()}),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
